// File: rtl/bcrypt_pkg.sv
// Shared types and constants for the Blowfish key-schedule / round sequencing blocks.
// Imported by the scheduler, its write-address generator and the benches.
package bcrypt_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      EXE  = 3'd3,
      FIN  = 3'd4,
      WB_L = 3'd5,
      WB_R = 3'd6,
      DONE = 3'd7
   } sched_state_t;

   typedef enum logic [2:0] {
      TGT_P  = 3'd0,
      TGT_S0 = 3'd1,
      TGT_S1 = 3'd2,
      TGT_S2 = 3'd3,
      TGT_S3 = 3'd4
   } wr_tgt_t;

   localparam int N_P        = 18;
   localparam int SBOX_DEPTH = 256;
   localparam int N_ENC_FILL = 521;

   localparam logic MODE_FILL = 1'b0;
   localparam logic MODE_ENC  = 1'b1;

   // Linear writeback word index: each encryption produces two words (L then R).
   function automatic logic [10:0] wb_word(input logic [9:0] enc, input logic half);
      return {enc, half};
   endfunction

endpackage

// File: rtl/bf_round_sched_if.sv
// Control/status bundle between the Blowfish round scheduler and its datapath/host.
// master drives start/mode and consumes strobes; slave is the scheduler.
interface bf_round_sched_if;

   logic       start;
   logic       mode;
   logic       busy;
   logic       done;
   logic       p_rd_en;
   logic [4:0] p_idx;
   logic       sb_rd_en;
   logic       round_en;
   logic       final_en;
   logic       wr_en;
   logic [2:0] wr_tgt;
   logic [7:0] wr_addr;
   logic       wr_half;
   logic [9:0] enc_cnt;

   modport master (
      output start,
      output mode,
      input  busy,
      input  done,
      input  p_rd_en,
      input  p_idx,
      input  sb_rd_en,
      input  round_en,
      input  final_en,
      input  wr_en,
      input  wr_tgt,
      input  wr_addr,
      input  wr_half,
      input  enc_cnt
   );

   modport slave (
      input  start,
      input  mode,
      output busy,
      output done,
      output p_rd_en,
      output p_idx,
      output sb_rd_en,
      output round_en,
      output final_en,
      output wr_en,
      output wr_tgt,
      output wr_addr,
      output wr_half,
      output enc_cnt
   );

endinterface

// File: rtl/bf_wb_addr_gen.sv
// Maps a linear ExpandKey writeback word index onto {target array, word address}:
// the first N_P words land in the P-array, the rest stream through S0..S3.
module bf_wb_addr_gen #(
   parameter int N_P        = 18,
   parameter int SBOX_DEPTH = 256
) (
   input  logic [10:0] w_i,
   output logic [2:0]  tgt_o,
   output logic [7:0]  addr_o
);
   import bcrypt_pkg::*;

   localparam int AW = $clog2(SBOX_DEPTH);

   logic [10:0] s_off;

   assign s_off = w_i - 11'(N_P);

   always_comb begin
      tgt_o  = 3'(TGT_P);
      addr_o = w_i[7:0];
      if (w_i >= 11'(N_P)) begin
         tgt_o  = 3'(s_off >> AW) + 3'(TGT_S0);
         addr_o = s_off[7:0];
      end
   end

endmodule

// File: rtl/bf_round_sched.sv
// Blowfish round sequencer: 16 Feistel rounds + whitening per encryption, optional
// L/R writeback into P/S for the full ExpandKey fill. All outputs are registered.
module bf_round_sched #(
   parameter int RD_LAT     = 1,
   parameter int N_ROUNDS   = 16,
   parameter int N_P        = 18,
   parameter int SBOX_DEPTH = 256,
   parameter int N_SBOX     = 4
) (
   input  logic           clk,
   input  logic           rst_l,
   bf_round_sched_if.slave sif
);
   import bcrypt_pkg::*;

   // Every P and S word is refilled once, two words per encryption.
   localparam int N_ENC = (N_P + N_SBOX * SBOX_DEPTH) / 2;

   sched_state_t state_q, state_d;
   logic [4:0]   round_q, round_d;
   logic [1:0]   wait_q,  wait_d;
   logic [9:0]   enc_cnt_q, enc_cnt_d;
   logic         mode_q,  mode_d;

   logic         busy_q,     busy_d;
   logic         done_q,     done_d;
   logic         p_rd_en_q,  p_rd_en_d;
   logic [4:0]   p_idx_q,    p_idx_d;
   logic         sb_rd_en_q, sb_rd_en_d;
   logic         round_en_q, round_en_d;
   logic         final_en_q, final_en_d;
   logic         wr_en_q,    wr_en_d;
   logic [2:0]   wr_tgt_q,   wr_tgt_d;
   logic [7:0]   wr_addr_q,  wr_addr_d;
   logic         wr_half_q,  wr_half_d;

   logic [2:0]   gen_tgt;
   logic [7:0]   gen_addr;

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      wait_d    = wait_q;
      enc_cnt_d = enc_cnt_q;
      mode_d    = mode_q;
      case (state_q)
         IDLE: begin
            if (sif.start) begin
               mode_d    = sif.mode;
               enc_cnt_d = '0;
               round_d   = '0;
               state_d   = RD;
            end
         end
         RD: begin
            wait_d  = '0;
            state_d = (RD_LAT > 1) ? WAIT : EXE;
         end
         WAIT: begin
            if (wait_q == 2'(RD_LAT - 2)) begin
               wait_d  = '0;
               state_d = EXE;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         EXE: begin
            round_d = round_q + 5'd1;
            state_d = (round_q < 5'(N_ROUNDS - 1)) ? RD : FIN;
         end
         FIN: begin
            state_d = (mode_q == MODE_ENC) ? DONE : WB_L;
         end
         WB_L: begin
            state_d = WB_R;
         end
         WB_R: begin
            if (enc_cnt_q == 10'(N_ENC - 1)) begin
               state_d = DONE;
            end else begin
               enc_cnt_d = enc_cnt_q + 10'd1;
               round_d   = '0;
               state_d   = RD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes are decoded from the state being entered so they are valid
   // in the very cycle that state is occupied.
   always_comb begin
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      sb_rd_en_d = (state_d == RD);
      p_rd_en_d  = (state_d == RD) || (state_d == FIN);
      round_en_d = (state_d == EXE);
      final_en_d = (state_d == FIN);
      wr_en_d    = (state_d == WB_L) || (state_d == WB_R);
      wr_half_d  = (state_d == WB_R);
      p_idx_d    = '0;
      if (state_d == RD) begin
         p_idx_d = round_d;
      end else if (state_d == FIN) begin
         p_idx_d = 5'(N_P - 2);
      end
      wr_tgt_d  = wr_en_d ? gen_tgt  : 3'd0;
      wr_addr_d = wr_en_d ? gen_addr : 8'd0;
   end

   bf_wb_addr_gen #(
      .N_P        (N_P),
      .SBOX_DEPTH (SBOX_DEPTH)
   ) u_wb_addr_gen (
      .w_i    (wb_word(enc_cnt_d, wr_half_d)),
      .tgt_o  (gen_tgt),
      .addr_o (gen_addr)
   );

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         round_q    <= '0;
         wait_q     <= '0;
         enc_cnt_q  <= '0;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         p_rd_en_q  <= 1'b0;
         p_idx_q    <= '0;
         sb_rd_en_q <= 1'b0;
         round_en_q <= 1'b0;
         final_en_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_tgt_q   <= '0;
         wr_addr_q  <= '0;
         wr_half_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         wait_q     <= wait_d;
         enc_cnt_q  <= enc_cnt_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         p_rd_en_q  <= p_rd_en_d;
         p_idx_q    <= p_idx_d;
         sb_rd_en_q <= sb_rd_en_d;
         round_en_q <= round_en_d;
         final_en_q <= final_en_d;
         wr_en_q    <= wr_en_d;
         wr_tgt_q   <= wr_tgt_d;
         wr_addr_q  <= wr_addr_d;
         wr_half_q  <= wr_half_d;
      end
   end

   assign sif.busy     = busy_q;
   assign sif.done     = done_q;
   assign sif.p_rd_en  = p_rd_en_q;
   assign sif.p_idx    = p_idx_q;
   assign sif.sb_rd_en = sb_rd_en_q;
   assign sif.round_en = round_en_q;
   assign sif.final_en = final_en_q;
   assign sif.wr_en    = wr_en_q;
   assign sif.wr_tgt   = wr_tgt_q;
   assign sif.wr_addr  = wr_addr_q;
   assign sif.wr_half  = wr_half_q;
   assign sif.enc_cnt  = enc_cnt_q;

endmodule
